// File: rtl/mem_bus_adapter.sv
// Core load/store to 32-bit word-addressed handshaked bus adapter.
// Builds byte enables, replicates store data across lanes and extends load data.
module mem_bus_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  read_op,
  input  logic [1:0]  write_op,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        misalign_err,
  output logic        op_err,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [TIMEOUT_W:0] TO_LIM = (TIMEOUT_W+1)'(TIMEOUT_CYCLES);

  state_e state_q, state_d;

  logic [31:0]          rdata_q, rdata_d;
  logic                 mis_q, mis_d;
  logic                 operr_q, operr_d;
  logic                 berr_q, berr_d;
  logic                 we_q, we_d;
  logic [31:0]          baddr_q, baddr_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          bwdata_q, bwdata_d;
  logic [1:0]           lane_q, lane_d;
  logic [2:0]           rop_q, rop_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  logic              rd_act, wr_act, active, op_bad, misal, to_hit;
  logic [TIMEOUT_W:0] cnt_inc;
  logic [3:0]        be_new;
  logic [31:0]       wd_new, ext;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;

  always_comb begin
    rd_act  = read_op != 3'b011;
    wr_act  = write_op != 2'b11;
    active  = rd_act || wr_act;
    op_bad  = (rd_act && wr_act) || (read_op[2:1] == 2'b11);
    misal   = 1'b0;
    if (rd_act) begin
      case (read_op)
        3'b001, 3'b101: misal = addr[0];
        3'b010:         misal = |addr[1:0];
        default:        misal = 1'b0;
      endcase
    end else if (wr_act) begin
      case (write_op)
        2'b01:   misal = addr[0];
        2'b10:   misal = |addr[1:0];
        default: misal = 1'b0;
      endcase
    end
    cnt_inc = {1'b0, cnt_q} + {{TIMEOUT_W{1'b0}}, 1'b1};
    // A count of zero disables the timeout entirely
    to_hit  = (TIMEOUT_CYCLES != 0) && (cnt_inc == TO_LIM);
  end

  always_comb begin
    case (write_op)
      2'b00: begin
        be_new = 4'b0001 << addr[1:0];
        wd_new = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_new = addr[1] ? 4'b1100 : 4'b0011;
        wd_new = {2{wdata[15:0]}};
      end
      2'b10: begin
        be_new = 4'b1111;
        wd_new = wdata;
      end
      default: begin
        be_new = 4'b1111;
        wd_new = '0;
      end
    endcase
  end

  always_comb begin
    byte_v = bus_rdata[{lane_q, 3'b000} +: 8];
    half_v = lane_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (rop_q)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b100:  ext = {24'b0, byte_v};
      3'b101:  ext = {16'b0, half_v};
      default: ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (active) state_d = (op_bad || misal) ? RESP : REQ;
      REQ:     if (bus_ack || to_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = ((state_q == IDLE) && active) || (state_q == REQ);
    bus_req = state_q == REQ;
    done    = state_q == RESP;
  end

  always_comb begin
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    operr_d  = operr_q;
    berr_d   = berr_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    lane_d   = lane_q;
    rop_d    = rop_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (active) begin
          if (op_bad) begin
            operr_d = 1'b1;
          end else if (misal) begin
            mis_d = 1'b1;
          end else begin
            we_d     = wr_act;
            baddr_d  = {addr[31:2], 2'b00};
            be_d     = be_new;
            bwdata_d = wd_new;
            lane_d   = addr[1:0];
            rop_d    = read_op;
            cnt_d    = '0;
          end
        end
      end
      REQ: begin
        // Ack takes priority over a timeout expiring in the same cycle
        if (bus_ack) begin
          if (!we_q) rdata_d = ext;
        end else if (to_hit) begin
          rdata_d = '0;
          berr_d  = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_inc[TIMEOUT_W-1:0];
        end
      end
      RESP: begin
        mis_d   = 1'b0;
        operr_d = 1'b0;
        berr_d  = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      mis_q    <= 1'b0;
      operr_q  <= 1'b0;
      berr_q   <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
      lane_q   <= '0;
      rop_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rdata_q  <= rdata_d;
      mis_q    <= mis_d;
      operr_q  <= operr_d;
      berr_q   <= berr_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
      lane_q   <= lane_d;
      rop_q    <= rop_d;
      cnt_q    <= cnt_d;
    end
  end

  assign rdata        = rdata_q;
  assign misalign_err = mis_q;
  assign op_err       = operr_q;
  assign bus_err      = berr_q;
  assign bus_we       = we_q;
  assign bus_addr     = baddr_q;
  assign bus_be       = be_q;
  assign bus_wdata    = bwdata_q;

endmodule

// File: tb/tb_mem_bus_adapter.sv
// Bench for mem_bus_adapter: directed vector table, reset/back-to-back sequences,
// and random transactions checked against a behavioural model.
module tb_mem_bus_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata;
  logic [2:0]  read_op;
  logic [1:0]  write_op;
  logic        stall, done, misalign_err, op_err, bus_err;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  mem_bus_adapter #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .read_op(read_op), .write_op(write_op), .stall(stall), .done(done),
    .rdata(rdata), .misalign_err(misalign_err), .op_err(op_err),
    .bus_err(bus_err), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  typedef struct {
    logic [2:0]  rop;
    logic [1:0]  wop;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_at;   // REQ cycle (1-based) in which ack is given; 0 = never
    logic [31:0] rword;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis, operr, berr;
    int          nreq;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr, bwdata;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        mis, operr, berr;
    int          nreq, nstall, done_cyc;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr, bwdata;
    logic        unstable;
  } obs_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(logic [2:0] rop, logic [1:0] wop, logic [31:0] a, logic [31:0] wd,
                               int ack, logic [31:0] rw, logic [31:0] erd, logic [2:0] flags,
                               int nreq, logic we, logic [3:0] be, logic [31:0] baddr,
                               logic [31:0] bwd);
    vec_t v;
    v.s.rop = rop; v.s.wop = wop; v.s.addr = a; v.s.wdata = wd; v.s.ack_at = ack; v.s.rword = rw;
    v.e.rdata = erd; v.e.mis = flags[2]; v.e.operr = flags[1]; v.e.berr = flags[0];
    v.e.nreq = nreq; v.e.we = we; v.e.be = be; v.e.baddr = baddr; v.e.bwdata = bwd;
    return v;
  endfunction

  // Reference: derived from access size and byte lane rather than per-op encodings
  function automatic exp_t model(stim_t s, logic [31:0] prev);
    exp_t e;
    bit rd, wr;
    int size, lane;
    logic [31:0] w, v;
    e.rdata = prev; e.mis = 0; e.operr = 0; e.berr = 0; e.nreq = 0; e.we = 0;
    e.be = 0; e.baddr = {s.addr[31:2], 2'b00}; e.bwdata = 0;
    rd = (s.rop != 3'd3);
    wr = (s.wop != 2'd3);
    lane = int'(s.addr[1:0]);
    if ((rd && wr) || s.rop >= 3'd6) begin
      e.operr = 1;
      return e;
    end
    if (rd) size = (s.rop == 3'd2) ? 4 : (s.rop == 3'd1 || s.rop == 3'd5) ? 2 : 1;
    else    size = (s.wop == 2'd2) ? 4 : (s.wop == 2'd1) ? 2 : 1;
    if (lane % size != 0) begin
      e.mis = 1;
      return e;
    end
    e.nreq = (s.ack_at >= 1 && s.ack_at <= 4) ? s.ack_at : 4;
    e.we = wr;
    if (wr) begin
      e.be = 4'(((1 << size) - 1) << lane);
      if (size == 1)      e.bwdata = {24'b0, s.wdata[7:0]} * 32'h01010101;
      else if (size == 2) e.bwdata = {16'b0, s.wdata[15:0]} * 32'h00010001;
      else                e.bwdata = s.wdata;
    end else begin
      e.be = 4'hF;
    end
    if (e.nreq == 4 && s.ack_at != 4) begin
      e.rdata = 0;
      e.berr = 1;
    end else if (rd) begin
      w = s.rword >> (8 * lane);
      if (size == 1) begin
        v = w & 32'hFF;
        if (s.rop == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
      end else if (size == 2) begin
        v = w & 32'hFFFF;
        if (s.rop == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic run_txn(input stim_t s, output obs_t o);
    bit seen;
    o.rdata = 'x; o.mis = 'x; o.operr = 'x; o.berr = 'x;
    o.nreq = 0; o.nstall = 0; o.done_cyc = -1; o.we = 0; o.be = 0;
    o.baddr = 0; o.bwdata = 0; o.unstable = 0;
    seen = 0;
    @(negedge clk);
    read_op = s.rop; write_op = s.wop; addr = s.addr; wdata = s.wdata;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      #1;
      if (stall) o.nstall = o.nstall + 1;
      if (bus_req) begin
        o.nreq = o.nreq + 1;
        if (o.nreq == 1) begin
          o.we = bus_we; o.be = bus_be; o.baddr = bus_addr; o.bwdata = bus_wdata;
        end else if (o.we !== bus_we || o.be !== bus_be || o.baddr !== bus_addr ||
                     o.bwdata !== bus_wdata) begin
          o.unstable = 1;
        end
        bus_ack   = (o.nreq == s.ack_at);
        bus_rdata = bus_ack ? s.rword : $urandom();
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom();
      end
      if (done) begin
        seen = 1;
        o.done_cyc = cyc;
        o.rdata = rdata; o.mis = misalign_err; o.operr = op_err; o.berr = bus_err;
        read_op = 3'b011; write_op = 2'b11;
      end else begin
        @(negedge clk);
      end
    end
    if (!seen) begin
      read_op = 3'b011; write_op = 2'b11; bus_ack = 1'b0;
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t o);
    chk($sformatf("%s.done_cyc", tag), 32'(o.done_cyc), 32'(e.nreq + 1));
    chk($sformatf("%s.stall_cycles", tag), 32'(o.nstall), 32'(e.nreq + 1));
    chk($sformatf("%s.req_cycles", tag), 32'(o.nreq), 32'(e.nreq));
    chk($sformatf("%s.rdata", tag), o.rdata, e.rdata);
    chk($sformatf("%s.misalign_err", tag), {31'b0, o.mis}, {31'b0, e.mis});
    chk($sformatf("%s.op_err", tag), {31'b0, o.operr}, {31'b0, e.operr});
    chk($sformatf("%s.bus_err", tag), {31'b0, o.berr}, {31'b0, e.berr});
    if (e.nreq > 0) begin
      chk($sformatf("%s.bus_addr", tag), o.baddr, e.baddr);
      chk($sformatf("%s.bus_be", tag), {28'b0, o.be}, {28'b0, e.be});
      chk($sformatf("%s.bus_we", tag), {31'b0, o.we}, {31'b0, e.we});
      if (e.we) chk($sformatf("%s.bus_wdata", tag), o.bwdata, e.bwdata);
      chk($sformatf("%s.bus_stable", tag), {31'b0, o.unstable}, 32'd0);
    end
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    obs_t  o;
    int    pick;
    logic [2:0] rops [10];

    reset = 1'b1; addr = '0; wdata = '0; read_op = 3'b011; write_op = 2'b11;
    bus_ack = 1'b0; bus_rdata = '0;

    tbl.push_back(mkv(3'd2, 2'd3, 32'h100, 32'h0, 3, 32'hDEADBEEF, 32'hDEADBEEF, 3'b000, 3, 0, 4'hF, 32'h100, 32'h0));
    tbl.push_back(mkv(3'd0, 2'd3, 32'h203, 32'h0, 1, 32'h80112233, 32'hFFFFFF80, 3'b000, 1, 0, 4'hF, 32'h200, 32'h0));
    tbl.push_back(mkv(3'd4, 2'd3, 32'h203, 32'h0, 1, 32'h80112233, 32'h00000080, 3'b000, 1, 0, 4'hF, 32'h200, 32'h0));
    tbl.push_back(mkv(3'd5, 2'd3, 32'h202, 32'h0, 1, 32'h80112233, 32'h00008011, 3'b000, 1, 0, 4'hF, 32'h200, 32'h0));
    tbl.push_back(mkv(3'd3, 2'd1, 32'h302, 32'h0000ABCD, 1, 32'h0, 32'h00008011, 3'b000, 1, 1, 4'hC, 32'h300, 32'hABCDABCD));
    tbl.push_back(mkv(3'd2, 2'd3, 32'h102, 32'h0, 1, 32'h0, 32'h00008011, 3'b100, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(3'd3, 2'd1, 32'h101, 32'h0, 1, 32'h0, 32'h00008011, 3'b100, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(3'd6, 2'd3, 32'h100, 32'h0, 1, 32'h0, 32'h00008011, 3'b010, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(3'd2, 2'd2, 32'h100, 32'h0, 1, 32'h0, 32'h00008011, 3'b010, 0, 0, 4'h0, 32'h0, 32'h0));
    tbl.push_back(mkv(3'd2, 2'd3, 32'h400, 32'h0, 0, 32'h0, 32'h00000000, 3'b001, 4, 0, 4'hF, 32'h400, 32'h0));
    tbl.push_back(mkv(3'd2, 2'd3, 32'h404, 32'h0, 4, 32'h12345678, 32'h12345678, 3'b000, 4, 0, 4'hF, 32'h404, 32'h0));
    tbl.push_back(mkv(3'd3, 2'd0, 32'h001, 32'h000000A5, 1, 32'h0, 32'h12345678, 3'b000, 1, 1, 4'h2, 32'h000, 32'hA5A5A5A5));
    tbl.push_back(mkv(3'd1, 2'd3, 32'h206, 32'h0, 2, 32'h9ABC0000, 32'hFFFF9ABC, 3'b000, 2, 0, 4'hF, 32'h204, 32'h0));
    tbl.push_back(mkv(3'd3, 2'd2, 32'h050, 32'hCAFEF00D, 2, 32'h0, 32'hFFFF9ABC, 3'b000, 2, 1, 4'hF, 32'h050, 32'hCAFEF00D));
    tbl.push_back(mkv(3'd1, 2'd3, 32'h100, 32'h0, 1, 32'h00007FFF, 32'h00007FFF, 3'b000, 1, 0, 4'hF, 32'h100, 32'h0));
    tbl.push_back(mkv(3'd3, 2'd0, 32'h203, 32'h00000012, 1, 32'h0, 32'h00007FFF, 3'b000, 1, 1, 4'h8, 32'h200, 32'h12121212));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset.stall", {31'b0, stall}, 32'd0);
    chk("reset.done", {31'b0, done}, 32'd0);
    chk("reset.bus_req", {31'b0, bus_req}, 32'd0);
    chk("reset.rdata", rdata, 32'd0);
    chk("reset.bus_addr", bus_addr, 32'd0);
    chk("reset.bus_be_we", {27'b0, bus_be, bus_we}, 32'd0);
    chk("reset.bus_wdata", bus_wdata, 32'd0);
    chk("reset.flags", {29'b0, misalign_err, op_err, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table, issued back-to-back
    foreach (tbl[i]) begin
      run_txn(tbl[i].s, o);
      compare($sformatf("vec%0d", i), tbl[i].e, o);
      exp_rd = tbl[i].e.rdata;
    end

    // Reset in the second REQ cycle abandons the transaction
    @(negedge clk);
    read_op = 3'd2; write_op = 2'd3; addr = 32'h600;
    #1 chk("rst_seq.stall_idle", {31'b0, stall}, 32'd1);
    @(negedge clk);
    #1 chk("rst_seq.req1", {31'b0, bus_req}, 32'd1);
    @(negedge clk);
    #1 chk("rst_seq.req2", {31'b0, bus_req}, 32'd1);
    reset = 1'b1; read_op = 3'b011; write_op = 2'b11;
    #1;
    chk("rst_seq.req_async", {31'b0, bus_req}, 32'd0);
    chk("rst_seq.stall", {31'b0, stall}, 32'd0);
    chk("rst_seq.rdata", rdata, 32'd0);
    chk("rst_seq.bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_rd = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk($sformatf("rst_seq.no_done%0d", i), {31'b0, done}, 32'd0);
    end
    s.rop = 3'd2; s.wop = 2'd3; s.addr = 32'h604; s.wdata = 0; s.ack_at = 2; s.rword = 32'h0BADF00D;
    e = model(s, exp_rd);
    run_txn(s, o);
    compare("rst_seq.lw", e, o);
    exp_rd = e.rdata;

    // Random transactions against the model
    rops = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd3, 3'd3, 3'd6, 3'd7};
    for (int n = 0; n < 150; n++) begin
      pick = int'($urandom_range(0, 9));
      s.rop = rops[pick];
      s.wop = 2'($urandom_range(0, 3));
      if (s.rop == 3'd3 && s.wop == 2'd3) s.wop = 2'($urandom_range(0, 2));
      s.addr   = $urandom();
      s.wdata  = $urandom();
      s.rword  = $urandom();
      s.ack_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 4));
      e = model(s, exp_rd);
      run_txn(s, o);
      compare($sformatf("rand%0d", n), e, o);
      exp_rd = e.rdata;
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_adapter.md
Name: mem_bus_adapter

Overview:
- Sits directly downstream of the core control unit's memory op outputs (mem_read_op / mem_write_op, address from the address mux, store data from rs2).
- Converts one core load/store per request into a handshaked 32-bit word-addressed external bus transaction.
- Generates byte enables and lane-replicated store data; extracts and sign/zero-extends load data.
- Stalls the core step counter while a transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 0, cycles bus_req may wait for bus_ack before aborting with bus_err; 0 disables the timeout
TIMEOUT_W, 8, width of the timeout counter; TIMEOUT_CYCLES must be < 2**TIMEOUT_W

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
addr  in  32  byte address from core
wdata  in  32  store data from core (rs2)
read_op  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU, 011 none; 110/111 illegal
write_op  in  2  00 SB, 01 SH, 10 SW, 11 none
stall  out  1  core must hold step, addr, wdata and ops while high
done  out  1  one-cycle pulse: transaction finished, rdata and error flags valid
rdata  out  32  extended load result; held until the next done
misalign_err  out  1  valid with done: access misaligned, no bus cycle issued
op_err  out  1  valid with done: illegal op encoding or read and write both requested
bus_err  out  1  valid with done: timeout expired
bus_req  out  1  external request, held until ack or abort
bus_we  out  1  1 = write
bus_addr  out  32  {addr[31:2], 2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  slave completes the transaction in the cycle it is sampled high
bus_rdata  in  32  read word, valid when bus_ack is high

Behaviour:
- State machine: IDLE, REQ, RESP.
- Reset values: state = IDLE; all outputs 0, including rdata, bus_addr, bus_be and bus_wdata.
- active = read_op != 011 || write_op != 11.
- stall is combinational: (state == IDLE && active) || state == REQ. stall is 0 in RESP, so the core advances on the edge that leaves RESP.
- IDLE, active:
  - Check errors in priority order: op_err (read and write both active, or read_op 110/111), then misalignment.
  - Misaligned: LH/LHU/SH with addr[0] = 1; LW/SW with addr[1:0] != 0.
  - On any error: go to RESP with the matching flag set, and never assert bus_req.
  - Otherwise register bus_addr, bus_we, bus_be, bus_wdata, lane (addr[1:0]) and the op. Go to REQ; bus_req is 1 from the next cycle.
- REQ:
  - bus_req = 1; bus_addr, bus_be, bus_we and bus_wdata are held stable.
  - On bus_ack: capture the extended result into rdata (reads only; writes leave rdata unchanged), drop bus_req, go to RESP.
  - When TIMEOUT_CYCLES > 0, the counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES: drop bus_req, rdata = 0, bus_err = 1, go to RESP.
  - If ack arrives in the same cycle the count is reached, ack wins.
- RESP: done = 1 for exactly one cycle, error flags valid alongside it, then IDLE. Error flags clear when leaving RESP.
- Minimum latency: done is asserted 2 cycles after op presentation when ack comes in the first REQ cycle; each ack wait cycle adds 1.
- Byte enables and store data:
  - SB: bus_be = 0001 << addr[1:0]; wdata[7:0] replicated to all 4 lanes.
  - SH: bus_be = addr[1] ? 1100 : 0011; wdata[15:0] replicated to both halves.
  - SW: bus_be = 1111; wdata passed through.
  - Reads: bus_be = 1111.
- Load extraction:
  - Byte = bus_rdata[8*lane +: 8]; half = addr[1] ? bus_rdata[31:16] : bus_rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Ops changing while stall = 1 is illegal core behaviour; the adapter uses only the registered copies.
- Reset asserted mid-REQ: bus_req drops asynchronously, and the abandoned transaction produces no done.
- Back-to-back: an op present in the cycle after RESP starts a new transaction.

Test Plan:
- LW addr 0x100, bus_rdata 0xDEADBEEF, ack in 3rd REQ cycle -> bus_addr 0x100, be 1111, stall high 4 cycles, done pulse, rdata 0xDEADBEEF.
- LB addr 0x203, bus_rdata 0x80112233, ack immediately -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x202 -> 0x00008011.
- SH addr 0x302, wdata 0x0000ABCD -> bus_we 1, be 1100, bus_wdata 0xABCDABCD, bus_addr 0x300, rdata unchanged.
- LW addr 0x102; SH addr 0x101; read_op 110 -> no bus_req ever, done after 1 cycle with misalign_err, misalign_err and op_err respectively.
- TIMEOUT_CYCLES = 4, bus_ack never high -> bus_req high exactly 4 cycles, then done with bus_err = 1, rdata 0. Ack on the 4th cycle -> normal completion, bus_err 0.
- Reset pulsed in the 2nd REQ cycle -> bus_req 0 in the same cycle, no done, stall 0, next LW completes normally.
